anton_neopixel_rx: RTL
======================

// Module: anton_neopixel_rx
// PURPOSE
//  Receiver/decoder for the NeoPixel single-wire stream: samples a WS2812-style data line and measures
//  each high pulse to decide the bit. Assembles 24-bit pixel words and detects the latch (reset) gap.
//  Forwards the stream after the first pixel, the same way a WS2812 chain does. Sits next to the stream
//  transmitter as a loopback checker and as a front end for daisy-chained controllers.
// PARAMETERS
//  ZERO_MIN     1   min high cycles accepted as a bit; shorter = glitch
//  ONE_MIN      4   high cycles >= ONE_MIN decode as '1', else '0'
//  HIGH_MAX     7   high cycles > HIGH_MAX = long-pulse error
//  RESET_CYCLES 64  consecutive low cycles that end a frame (latch)
//  INDEX_BITS   13  width of pixel_index (8192 pixels)
// PORTS
//  clk            in   1   system clock
//  rst            in   1   asynchronous, active-high reset
//  enable         in   1   0 = receiver held in SYNC_GAP, no outputs generated
//  neo_in         in   1   asynchronous serial data line
//  pixel_data     out  24  last completed pixel; first received bit in [23]
//  pixel_valid    out  1   1-clk pulse, pixel_data/pixel_index valid
//  pixel_index    out  INDEX_BITS  index of pixel in pixel_data within the current frame
//  frame_done     out  1   1-clk pulse on latch gap after >=1 received bit
//  err_glitch     out  1   1-clk pulse, high pulse < ZERO_MIN
//  err_long       out  1   1-clk pulse, high pulse > HIGH_MAX
//  err_partial    out  1   1-clk pulse, latch gap with 1..23 bits pending
//  neo_out        out  1   forwarded stream for the next device
// BEHAVIOUR
//  - Reset: every output 0, counters 0, state SYNC_GAP.
//  - neo_in passes a 2-flop synchronizer (s). All decoding uses s and s_d (previous s).
//  - States and transitions:
//    SYNC_GAP: low_cnt++ while s=0; s=1 clears low_cnt. low_cnt==RESET_CYCLES -> IDLE.
//    IDLE: s rising -> HIGH, high_cnt=1.
//    HIGH: high_cnt++ (saturating at HIGH_MAX+1).
//      high_cnt>HIGH_MAX -> err_long, SYNC_GAP.
//      On s falling, high_cnt<ZERO_MIN -> err_glitch, SYNC_GAP.
//      Otherwise shift in bit (high_cnt>=ONE_MIN), bit_cnt++, low_cnt=1 -> LOW.
//    LOW: low_cnt++. s rising -> HIGH, high_cnt=1.
//      low_cnt==RESET_CYCLES -> frame end, IDLE.
//  - Pixel: on the 24th bit, pixel_data<=shift register and pixel_valid=1 on the next clk.
//    pixel_index = count of pixels already completed this frame. bit_cnt->0. The index counter wraps modulo 2^INDEX_BITS.
//  - Latency: neo_in falling edge of a pixel's 24th bit -> pixel_valid high 3 clk later.
//  - Frame end: frame_done pulses if any bit was received since the last latch. err_partial pulses in the
//    same clk if bit_cnt!=0. Partial bits are discarded; pixel counter and bit_cnt clear.
//  - Any error: partial bits discarded, pixel counter kept. The receiver resyncs via SYNC_GAP and the next
//    latch gap still gives frame_done.
//  - Forwarding: a fwd flag sets the clk pixel 0 completes. While fwd=1, neo_out<=s (registered). Otherwise neo_out=0.
//    Pixel 0's own bits are never forwarded. fwd clears at frame end, on error, and on enable=0.
//  - enable=0 mid-frame: state SYNC_GAP, bit/pixel counters clear, no pulses generated.
//  - rst mid-frame: immediate return to the reset values above. No frame_done.
//  - Simultaneous: frame-end pulses and the last pixel_valid are never in the same clk, since the gap follows the bit.
// TESTING
//  - Drive 64 clk low, then 24 bits of 0xFF00D5 (slot=1clk: '1'=5H+3L, '0'=2H+6L), then 64 low.
//    Expect pixel_valid with data 0xFF00D5, index 0, then frame_done. No errors.
//  - 3 pixels 0xFF00D5, 0x008800, 0x000090 then latch: valid x3 at index 0,1,2. neo_out replays only
//    the last two pixels' waveform, delayed 3 clk; after frame_done, index restarts at 0.
//  - Mid-pixel single 0-clk-wide... 1-clk high with ZERO_MIN=2 override: err_glitch.
//    Next clean frame decodes correctly.
//  - 9-clk high pulse: err_long pulse. Remaining bits are ignored until a 64-clk gap, then normal decode.
//  - 10 bits then 64 low: err_partial and frame_done in the same clk. No pixel_valid.
//  - Assert rst at bit 12 of pixel 1: all outputs 0 immediately. No decode until a 64-clk gap is seen.

Source files
------------

// File: rtl/anton_neopixel_rx.sv
// anton_neopixel_rx
// Decodes a WS2812-style single-wire stream. Each high pulse is measured on
// the synchronised line; long pulses decode as '1' and short ones as '0'.
// Every 24 bits make one pixel word, and a long low gap latches the frame.
// After pixel 0 of a frame, the synchronised line is forwarded on neo_out.
// This matches how the next device in a WS2812 chain sees the stream.
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   enable       0 holds the receiver in SYNC_GAP and suppresses all pulses
//   neo_in       asynchronous serial data line
//   pixel_data   last completed pixel; first received bit in [23]
//   pixel_valid  1-clk pulse, pixel_data/pixel_index valid
//   pixel_index  pixel position of pixel_data within the current frame
//   frame_done   1-clk pulse on a latch gap after at least one received bit
//   err_glitch   1-clk pulse, high pulse shorter than ZERO_MIN
//   err_long     1-clk pulse, high pulse longer than HIGH_MAX
//   err_partial  1-clk pulse, latch gap with 1..23 bits pending
//   neo_out      forwarded stream for the next device
module anton_neopixel_rx #(
  parameter int ZERO_MIN     = 1,
  parameter int ONE_MIN      = 4,
  parameter int HIGH_MAX     = 7,
  parameter int RESET_CYCLES = 64,
  parameter int INDEX_BITS   = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  neo_in,
  output logic [23:0]           pixel_data,
  output logic                  pixel_valid,
  output logic [INDEX_BITS-1:0] pixel_index,
  output logic                  frame_done,
  output logic                  err_glitch,
  output logic                  err_long,
  output logic                  err_partial,
  output logic                  neo_out
);

  localparam int LW = $clog2(RESET_CYCLES + 1);
  localparam int HW = $clog2(HIGH_MAX + 2);
  localparam logic [LW-1:0] LOW_END  = LW'(RESET_CYCLES);
  localparam logic [LW-1:0] LOW_ZERO = LW'(0);
  localparam logic [LW-1:0] LOW_ONE  = LW'(1);
  localparam logic [HW-1:0] H_MAX    = HW'(HIGH_MAX);
  localparam logic [HW-1:0] Z_MIN    = HW'(ZERO_MIN);
  localparam logic [HW-1:0] O_MIN    = HW'(ONE_MIN);
  localparam logic [HW-1:0] H_ONE    = HW'(1);
  localparam logic [INDEX_BITS-1:0] PIX_ZERO = INDEX_BITS'(0);

  typedef enum logic [1:0] {
    SYNC_GAP = 2'd0,
    IDLE     = 2'd1,
    HIGH     = 2'd2,
    LOW      = 2'd3
  } state_t;

  state_t                  state, state_n;
  logic                    sync1, s, s_d;
  logic [LW-1:0]           low_cnt, low_cnt_n;
  logic [HW-1:0]           high_cnt, high_cnt_n;
  logic [4:0]              bit_cnt, bit_cnt_n;
  logic [23:0]             shift, shift_n;
  logic [INDEX_BITS-1:0]   pix_cnt, pix_cnt_n, index_n;
  logic                    any_bit, any_bit_n;
  logic                    fwd, fwd_n;
  logic [23:0]             data_n;
  logic                    pv_n, fd_n, eg_n, el_n, ep_n;
  logic                    rising, falling, bit_val, latch, err;

  assign rising  = s & ~s_d;
  assign falling = ~s & s_d;

  // Next-state, counter and pulse computation.
  always_comb begin
    state_n    = state;
    low_cnt_n  = low_cnt;
    high_cnt_n = high_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    pix_cnt_n  = pix_cnt;
    index_n    = pixel_index;
    any_bit_n  = any_bit;
    fwd_n      = fwd;
    data_n     = pixel_data;
    pv_n       = 1'b0;
    fd_n       = 1'b0;
    eg_n       = 1'b0;
    el_n       = 1'b0;
    ep_n       = 1'b0;
    latch      = 1'b0;
    err        = 1'b0;
    bit_val    = (high_cnt >= O_MIN);
    if (!enable) begin
      state_n   = SYNC_GAP;
      low_cnt_n = LOW_ZERO;
      bit_cnt_n = 5'd0;
      pix_cnt_n = PIX_ZERO;
      any_bit_n = 1'b0;
      fwd_n     = 1'b0;
    end else begin
      case (state)
        SYNC_GAP: begin
          if (s) begin
            low_cnt_n = LOW_ZERO;
          end else if (low_cnt == LOW_END) begin
            latch = 1'b1;
          end else begin
            low_cnt_n = low_cnt + LOW_ONE;
          end
        end
        IDLE: begin
          if (rising) begin
            state_n    = HIGH;
            high_cnt_n = H_ONE;
          end else begin
            state_n = IDLE;
          end
        end
        HIGH: begin
          if (high_cnt > H_MAX) begin
            el_n = 1'b1;
            err  = 1'b1;
          end else if (falling) begin
            if (high_cnt < Z_MIN) begin
              eg_n = 1'b1;
              err  = 1'b1;
            end else begin
              shift_n   = {shift[22:0], bit_val};
              any_bit_n = 1'b1;
              low_cnt_n = LOW_ONE;
              state_n   = LOW;
              if (bit_cnt == 5'd23) begin
                data_n    = {shift[22:0], bit_val};
                pv_n      = 1'b1;
                index_n   = pix_cnt;
                pix_cnt_n = pix_cnt + INDEX_BITS'(1);
                bit_cnt_n = 5'd0;
                fwd_n     = 1'b1;
              end else begin
                bit_cnt_n = bit_cnt + 5'd1;
              end
            end
          end else begin
            // Bounded by the long-pulse check above, so this never overflows.
            high_cnt_n = high_cnt + H_ONE;
          end
        end
        LOW: begin
          if (rising) begin
            state_n    = HIGH;
            high_cnt_n = H_ONE;
          end else if (low_cnt == LOW_END) begin
            latch = 1'b1;
          end else begin
            low_cnt_n = low_cnt + LOW_ONE;
          end
        end
        default: begin
          state_n   = SYNC_GAP;
          low_cnt_n = LOW_ZERO;
        end
      endcase

      // A latch gap closes the frame; pending bits are dropped.
      if (latch) begin
        state_n   = IDLE;
        low_cnt_n = LOW_ZERO;
        fd_n      = any_bit;
        ep_n      = any_bit & (bit_cnt != 5'd0);
        any_bit_n = 1'b0;
        pix_cnt_n = PIX_ZERO;
        bit_cnt_n = 5'd0;
        fwd_n     = 1'b0;
      end else begin
        fd_n = 1'b0;
      end

      // Errors drop partial bits but keep the pixel count and any_bit, so the
      // next latch gap still reports the frame.
      if (err) begin
        state_n   = SYNC_GAP;
        low_cnt_n = LOW_ZERO;
        bit_cnt_n = 5'd0;
        fwd_n     = 1'b0;
      end else begin
        err = 1'b0;
      end
    end
  end

  // State, counters, synchroniser and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1       <= 1'b0;
      s           <= 1'b0;
      s_d         <= 1'b0;
      state       <= SYNC_GAP;
      low_cnt     <= LOW_ZERO;
      high_cnt    <= HW'(0);
      bit_cnt     <= 5'd0;
      shift       <= 24'd0;
      pix_cnt     <= PIX_ZERO;
      any_bit     <= 1'b0;
      fwd         <= 1'b0;
      pixel_data  <= 24'd0;
      pixel_valid <= 1'b0;
      pixel_index <= PIX_ZERO;
      frame_done  <= 1'b0;
      err_glitch  <= 1'b0;
      err_long    <= 1'b0;
      err_partial <= 1'b0;
      neo_out     <= 1'b0;
    end else begin
      sync1       <= neo_in;
      s           <= sync1;
      s_d         <= s;
      state       <= state_n;
      low_cnt     <= low_cnt_n;
      high_cnt    <= high_cnt_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      pix_cnt     <= pix_cnt_n;
      any_bit     <= any_bit_n;
      fwd         <= fwd_n;
      pixel_data  <= data_n;
      pixel_valid <= pv_n;
      pixel_index <= index_n;
      frame_done  <= fd_n;
      err_glitch  <= eg_n;
      err_long    <= el_n;
      err_partial <= ep_n;
      neo_out     <= fwd & s;
    end
  end

endmodule
